// File: rtl/tt_lane_alu_pkg.sv
// Shared mode encodings and width helpers for the lane accumulate ALU.
package tt_lane_alu_pkg;

    localparam logic [1:0] MODE_AND4  = 2'd0;
    localparam logic [1:0] MODE_ABNCD = 2'd1;
    localparam logic [1:0] MODE_SUM   = 2'd2;
    localparam logic [1:0] MODE_ACC   = 2'd3;

    // Width that holds the sum of a+b+c+d over every lane without loss.
    function automatic int unsigned inc_width(input int unsigned lane_w, input int unsigned lanes);
        return lane_w + 32'd2 + $clog2(lanes);
    endfunction

endpackage

// File: rtl/tt_lane_alu_lane.sv
// Combinational single-lane function unit: bitwise modes, lane sum and carry.
module tt_lane_alu_lane
    import tt_lane_alu_pkg::*;
#(
    parameter int unsigned LANE_W = 2
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic [LANE_W-1:0] c,
    input  logic [LANE_W-1:0] d,
    input  logic [1:0]        mode,
    output logic [LANE_W-1:0] res,
    output logic              cout,
    output logic [LANE_W+1:0] lane_sum
);

    localparam int unsigned SW = LANE_W + 2;

    always_comb begin
        lane_sum = SW'(a) + SW'(b) + SW'(c) + SW'(d);
        res      = '0;
        cout     = 1'b0;
        case (mode)
            MODE_AND4:  res = a & b & c & d;
            MODE_ABNCD: res = (a & b) | (~c & d);
            MODE_SUM: begin
                res  = lane_sum[LANE_W-1:0];
                cout = |lane_sum[SW-1:LANE_W];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tt_um_lane_accum_alu.sv
// Multi-lane ALU with running accumulator behind a 2-stage valid/ready pipeline.
module tt_um_lane_accum_alu
    import tt_lane_alu_pkg::*;
#(
    parameter int unsigned LANE_W = 2,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ACC_W  = 8,
    parameter int unsigned SAT    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ena,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode,
    input  logic [LANES*LANE_W-1:0] op_a,
    input  logic [LANES*LANE_W-1:0] op_b,
    input  logic [LANES*LANE_W-1:0] op_c,
    input  logic [LANES*LANE_W-1:0] op_d,
    input  logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] res,
    output logic [LANES-1:0]        cout,
    output logic [ACC_W-1:0]        acc,
    output logic                    ovf
);

    localparam int unsigned BW  = LANES * LANE_W;
    localparam int unsigned LSW = LANE_W + 2;
    localparam int unsigned IW  = inc_width(LANE_W, LANES);
    localparam int unsigned SW  = ((IW > ACC_W) ? IW : ACC_W) + 1;

    logic              s1_v;
    logic [1:0]        s1_mode;
    logic [BW-1:0]     s1_a, s1_b, s1_c, s1_d;

    logic [BW-1:0]     lane_res;
    logic [LANES-1:0]  lane_cout;
    logic [LANES*LSW-1:0] lane_sums;

    logic              s2_adv, s1_adv, accept, acc_xfer;
    logic [IW-1:0]     inc;
    logic [ACC_W-1:0]  acc_base, acc_next;
    logic [SW-1:0]     acc_sum;
    logic              acc_carry;
    logic [BW-1:0]     acc_res;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tt_lane_alu_lane #(.LANE_W(LANE_W)) u_lane (
            .a        (s1_a[i*LANE_W +: LANE_W]),
            .b        (s1_b[i*LANE_W +: LANE_W]),
            .c        (s1_c[i*LANE_W +: LANE_W]),
            .d        (s1_d[i*LANE_W +: LANE_W]),
            .mode     (s1_mode),
            .res      (lane_res[i*LANE_W +: LANE_W]),
            .cout     (lane_cout[i]),
            .lane_sum (lane_sums[i*LSW +: LSW])
        );
    end

    // Handshake: S1 moves only into a free (or draining) S2.
    always_comb begin
        s2_adv   = ~out_valid | out_ready;
        s1_adv   = s1_v & s2_adv;
        in_ready = ena & ~reset & (~s1_v | s1_adv);
        accept   = in_valid & in_ready;
        acc_xfer = s1_adv & (s1_mode == MODE_ACC);
    end

    // Accumulator next value; a same-cycle clear zeroes the base before adding.
    always_comb begin
        inc = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            inc = inc + IW'(lane_sums[i*LSW +: LSW]);
        end
        acc_base  = acc_clr ? '0 : acc;
        acc_sum   = SW'(acc_base) + SW'(inc);
        acc_carry = |acc_sum[SW-1:ACC_W];
        acc_next  = (acc_carry && (SAT != 0)) ? '1 : acc_sum[ACC_W-1:0];
        acc_res   = BW'(acc_next);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v      <= 1'b0;
            s1_mode   <= MODE_AND4;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_c      <= '0;
            s1_d      <= '0;
            out_valid <= 1'b0;
            res       <= '0;
            cout      <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (ena) begin
            if (~s1_v | s1_adv) begin
                s1_v <= accept;
            end
            if (accept) begin
                s1_mode <= mode;
                s1_a    <= op_a;
                s1_b    <= op_b;
                s1_c    <= op_c;
                s1_d    <= op_d;
            end
            if (s2_adv) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    res  <= (s1_mode == MODE_ACC) ? acc_res : lane_res;
                    cout <= lane_cout;
                end
            end
            if (acc_xfer) begin
                acc <= acc_next;
                ovf <= (~acc_clr & ovf) | acc_carry;
            end else if (acc_clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end
        end
    end

endmodule
